controlador_bin_bcd_display: RTL and testbench
==============================================

Name: controlador_bin_bcd_display

Overview:
Sequencer that converts a binary value into four BCD digits for the 4-digit 7-segment display controller, using iterative double-dabble at one shift per clock. It sits between the application datapath (counters, sensors) and the display controller's four data inputs. Its digit outputs hold the last completed result, so the display never shows partial conversions. It has a start/busy/done handshake and flags out-of-range values.

Parameters:
SUPRIME_CEROS, 0, 1 = replace leading-zero digits with CODIGO_BLANCO; the units digit is never blanked.
CODIGO_BLANCO, 4'hF, nibble code driven for blanked or error digits; the display controller renders it as all segments off.

Ports:
i_Clk  input  1  system clock, rising edge.
i_Rst  input  1  asynchronous reset, active-high.
i_Dato  input  14  binary value to convert; valid range 0..9999.
i_Inicio  input  1  start request, sampled only in state REPOSO.
o_Ocupado  output  1  conversion in progress.
o_Listo  output  1  one-cycle pulse when digits update.
o_Error  output  1  last conversion had i_Dato > 9999.
o_Digito_1  output  4  units digit; connects to the display controller's i_Datos_1.
o_Digito_2  output  4  tens digit; connects to i_Datos_2.
o_Digito_3  output  4  hundreds digit; connects to i_Datos_3.
o_Digito_4  output  4  thousands digit; connects to i_Datos_4.

Behaviour:
- Reset (asynchronous, i_Rst=1): state REPOSO, o_Digito_1..4=0, o_Ocupado=0, o_Listo=0, o_Error=0, shift register and iteration counter cleared. Reset mid-conversion aborts it; no o_Listo is issued.
- FSM states: REPOSO, DESPLAZA, FIN.
- REPOSO, i_Inicio=1 at edge N:
  - capture i_Dato into the 14-bit binary shift register;
  - clear the 16-bit BCD accumulator;
  - set the counter to 14;
  - go to DESPLAZA; o_Ocupado=1 after edge N.
- DESPLAZA, each edge:
  - add 3 to every BCD nibble >= 5 (combinational);
  - shift {BCD, binary} left by 1;
  - decrement the counter;
  - after the 14th shift (edge N+14), go to FIN.
- FIN, edge N+15:
  - register the digit outputs;
  - o_Listo=1 for exactly one cycle;
  - o_Ocupado=0;
  - return to REPOSO.
- Total latency: start edge to result = 15 clocks. The earliest next start is sampled at edge N+16, giving a minimum period of 16 clocks.
- i_Inicio in DESPLAZA or FIN is ignored. No queueing.
- i_Dato is only sampled at edge N; later changes do not affect the conversion in progress.
- Range check is done on the captured value:
  - if > 9999, the conversion still runs the full 15 cycles;
  - at FIN, all four digits = CODIGO_BLANCO and o_Error=1.
  - o_Error is cleared at FIN of the next in-range conversion.
- Leading-zero blanking (SUPRIME_CEROS=1) is applied at FIN, from the most significant digit downward. It stops at the first non-zero digit or at o_Digito_1.
- o_Digito_1..4 change only at FIN edges or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - FSM state encodings (REPOSO, DESPLAZA, FIN);
  - ITERACIONES=14;
  - VALOR_MAX=9999;
  - default CODIGO_BLANCO.
- One sub-module is natural: ajuste_bcd, a combinational add-3-if->=5 on one nibble, instantiated 4 times.

Test Plan:
1. Reset, i_Dato=9751, i_Inicio pulse at edge N -> o_Ocupado=1 for edges N..N+14. o_Listo high for one cycle after N+15. o_Digito_1..4 = 1,5,7,9 and o_Error=0. Digits stay at 0 during the conversion.
2. i_Dato=9999 -> 9,9,9,9. i_Dato=0 with SUPRIME_CEROS=0 -> 0,0,0,0. i_Dato=0 with SUPRIME_CEROS=1 -> 0,F,F,F. i_Dato=305 with SUPRIME_CEROS=1 -> 5,0,3,F.
3. i_Dato=12000 -> after 15 clocks o_Error=1 and digits F,F,F,F. Next, i_Dato=42 -> o_Error=0 and digits 2,4,0,0.
4. Start at N with i_Dato=1234. Second i_Inicio at N+5 with i_Dato=8888 -> ignored: a single o_Listo at N+15 and digits 4,3,2,1.
5. Assert i_Rst asynchronously mid-cycle at N+7 -> outputs return to reset values immediately with no o_Listo. After release, a new start with i_Dato=56 -> 6,5,0,0 after 15 clocks.
6. i_Inicio held at 1 continuously, i_Dato=77 -> o_Listo pulses every 16 clocks (first at N+15, next at N+31) and o_Ocupado is low for exactly one cycle between conversions.

Source files
------------

// File: rtl/controlador_bin_bcd_display_pkg.sv
// ----------------------------------------------------------------------------
// controlador_bin_bcd_display_pkg: shared types, constants, digit formatting. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package controlador_bin_bcd_display_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int ITERACIONES  = 14;
  localparam int VALOR_MAX    = 9999;
  localparam int ANCHO_BIN    = 14;
  localparam int ANCHO_NIBBLE = 4;
  localparam int NUM_DIGITOS  = 4;
  localparam int ANCHO_BCD    = ANCHO_NIBBLE * NUM_DIGITOS;
  localparam int ANCHO_CNT    = 4;

  localparam logic [ANCHO_NIBBLE-1:0] CODIGO_BLANCO_DEF = 4'hF;
  localparam logic [ANCHO_BIN-1:0]    LIMITE_BIN        = ANCHO_BIN'(VALOR_MAX);
  localparam logic [ANCHO_CNT-1:0]    CNT_INICIAL       = ANCHO_CNT'(ITERACIONES);

  // Final digit word {thousands, hundreds, tens, units}: error blanks all,
  // otherwise leading zeros are blanked from the top down, never the units.
  function automatic logic [ANCHO_BCD-1:0] formatea_digitos(
    input logic [ANCHO_BCD-1:0]    bcd,
    input logic                    suprime,
    input logic                    error,
    input logic [ANCHO_NIBBLE-1:0] blanco
  );
    logic [ANCHO_BCD-1:0] r;
    logic                 lider;
    r     = bcd;
    lider = suprime;
    if (error) begin
      r = {NUM_DIGITOS{blanco}};
    end else begin
      for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
        if (lider && (r[ANCHO_NIBBLE*i +: ANCHO_NIBBLE] == '0)) begin
          r[ANCHO_NIBBLE*i +: ANCHO_NIBBLE] = blanco;
        end else begin
          lider = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_bin_bcd_display_ajuste_bcd.sv
// ----------------------------------------------------------------------------
// ajuste_bcd: double-dabble correction, adds 3 to a nibble that is >= 5. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ajuste_bcd
  import controlador_bin_bcd_display_pkg::*;
(
  input  logic [ANCHO_NIBBLE-1:0] i_Nibble,
  output logic [ANCHO_NIBBLE-1:0] o_Nibble
);

  always_comb begin
    o_Nibble = i_Nibble;
    if (i_Nibble >= 4'd5) begin
      o_Nibble = i_Nibble + 4'd3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/controlador_bin_bcd_display.sv
// ----------------------------------------------------------------------------
// controlador_bin_bcd_display: start/busy/done binary-to-4-digit-BCD sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module controlador_bin_bcd_display
  import controlador_bin_bcd_display_pkg::*;
#(
  parameter bit                      SUPRIME_CEROS = 1'b0,
  parameter logic [ANCHO_NIBBLE-1:0] CODIGO_BLANCO = CODIGO_BLANCO_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [ANCHO_BIN-1:0]    i_Dato,
  input  logic                    i_Inicio,
  output logic                    o_Ocupado,
  output logic                    o_Listo,
  output logic                    o_Error,
  output logic [ANCHO_NIBBLE-1:0] o_Digito_1,
  output logic [ANCHO_NIBBLE-1:0] o_Digito_2,
  output logic [ANCHO_NIBBLE-1:0] o_Digito_3,
  output logic [ANCHO_NIBBLE-1:0] o_Digito_4
);

  estado_t                estado_q;
  logic [ANCHO_BIN-1:0]   bin_q;
  logic [ANCHO_BCD-1:0]   bcd_q;
  logic [ANCHO_CNT-1:0]   cnt_q;
  logic                   fuera_q;
  logic                   ocupado_q;
  logic                   listo_q;
  logic                   error_q;
  logic [ANCHO_BCD-1:0]   digitos_q;

  logic [ANCHO_BCD-1:0]   bcd_aj_d;
  logic [ANCHO_BCD-1:0]   digitos_d;

  generate
    for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
      ajuste_bcd u_ajuste (
        .i_Nibble (bcd_q[ANCHO_NIBBLE*g +: ANCHO_NIBBLE]),
        .o_Nibble (bcd_aj_d[ANCHO_NIBBLE*g +: ANCHO_NIBBLE])
      );
    end
  endgenerate

  always_comb begin
    digitos_d = formatea_digitos(bcd_q, SUPRIME_CEROS, fuera_q, CODIGO_BLANCO);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      estado_q  <= REPOSO;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      fuera_q   <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
      digitos_q <= '0;
    end else begin
      listo_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (i_Inicio) begin
            bin_q     <= i_Dato;
            bcd_q     <= '0;
            cnt_q     <= CNT_INICIAL;
            fuera_q   <= (i_Dato > LIMITE_BIN);
            ocupado_q <= 1'b1;
            estado_q  <= DESPLAZA;
          end
        end
        DESPLAZA: begin
          {bcd_q, bin_q} <= {bcd_aj_d[ANCHO_BCD-2:0], bin_q, 1'b0};
          // A carry out of the thousands digit also means the value cannot fit.
          fuera_q <= fuera_q | bcd_aj_d[ANCHO_BCD-1];
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == 4'd1) begin
            estado_q <= FIN;
          end
        end
        FIN: begin
          digitos_q <= digitos_d;
          error_q   <= fuera_q;
          listo_q   <= 1'b1;
          ocupado_q <= 1'b0;
          estado_q  <= REPOSO;
        end
        default: begin
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign o_Ocupado  = ocupado_q;
  assign o_Listo    = listo_q;
  assign o_Error    = error_q;
  assign o_Digito_1 = digitos_q[3:0];
  assign o_Digito_2 = digitos_q[7:4];
  assign o_Digito_3 = digitos_q[11:8];
  assign o_Digito_4 = digitos_q[15:12];

endmodule

`default_nettype wire

// File: tb/tb_controlador_bin_bcd_display.sv
// ----------------------------------------------------------------------------
// tb_controlador_bin_bcd_display: bench for both blanking settings side by side. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_controlador_bin_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] dato;
  logic        inicio;

  logic        oc0, li0, er0, oc1, li1, er1;
  logic [3:0]  a1, a2, a3, a4, b1, b2, b3, b4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] prev0, prev1;
  logic        perr;

  typedef struct {
    int          dato;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        err;
  } vec_t;

  vec_t tabla[6];

  always #5 clk = ~clk;

  controlador_bin_bcd_display #(.SUPRIME_CEROS(1'b0), .CODIGO_BLANCO(4'hF)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Dato(dato), .i_Inicio(inicio),
    .o_Ocupado(oc0), .o_Listo(li0), .o_Error(er0),
    .o_Digito_1(a1), .o_Digito_2(a2), .o_Digito_3(a3), .o_Digito_4(a4)
  );

  controlador_bin_bcd_display #(.SUPRIME_CEROS(1'b1), .CODIGO_BLANCO(4'hF)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Dato(dato), .i_Inicio(inicio),
    .o_Ocupado(oc1), .o_Listo(li1), .o_Error(er1),
    .o_Digito_1(b1), .o_Digito_2(b2), .o_Digito_3(b3), .o_Digito_4(b4)
  );

  // Reference: decimal digits by division, then leading-zero blanking.
  function automatic logic [15:0] modelo(input int v, input bit supr);
    logic [3:0] d[4];
    int         t;
    bit         lider;
    if (v > 9999) return 16'hFFFF;
    t = v;
    for (int i = 0; i < 4; i++) begin
      d[i] = 4'(t % 10);
      t    = t / 10;
    end
    lider = supr;
    for (int i = 3; i >= 1; i--) begin
      if (lider && d[i] == 4'd0) d[i] = 4'hF;
      else lider = 1'b0;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eoc, input logic eli,
                           input logic [15:0] e0, input logic [15:0] e1, input logic eer);
    chk({tag, " ocupado0"}, 32'(oc0), 32'(eoc));
    chk({tag, " ocupado1"}, 32'(oc1), 32'(eoc));
    chk({tag, " listo0"},   32'(li0), 32'(eli));
    chk({tag, " listo1"},   32'(li1), 32'(eli));
    chk({tag, " error0"},   32'(er0), 32'(eer));
    chk({tag, " error1"},   32'(er1), 32'(eer));
    chk({tag, " digitos0"}, 32'({a4, a3, a2, a1}), 32'(e0));
    chk({tag, " digitos1"}, 32'({b4, b3, b2, b1}), 32'(e1));
  endtask

  // Start at edge N, optionally retrigger at edge N+inject, check every cycle to N+16.
  task automatic run_conv(input int val, input int inject, input int inj_val,
                          input logic [15:0] e0, input logic [15:0] e1,
                          input logic eer, input string tag);
    @(negedge clk);
    dato   = 14'(val);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    dato   = 14'($urandom_range(0, 16383));
    for (int k = 0; k < 15; k++) begin
      check_all($sformatf("%s busy k=%0d", tag, k), 1'b1, 1'b0, prev0, prev1, perr);
      if (k + 1 == inject) begin
        inicio = 1'b1;
        dato   = 14'(inj_val);
      end else begin
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    check_all({tag, " done"}, 1'b0, 1'b1, e0, e1, eer);
    prev0 = e0;
    prev1 = e1;
    perr  = eer;
    @(negedge clk);
    check_all({tag, " after"}, 1'b0, 1'b0, e0, e1, eer);
  endtask

  initial begin
    tabla[0] = '{9751,  16'h9751, 16'h9751, 1'b0};
    tabla[1] = '{9999,  16'h9999, 16'h9999, 1'b0};
    tabla[2] = '{0,     16'h0000, 16'hFFF0, 1'b0};
    tabla[3] = '{305,   16'h0305, 16'hF305, 1'b0};
    tabla[4] = '{12000, 16'hFFFF, 16'hFFFF, 1'b1};
    tabla[5] = '{42,    16'h0042, 16'hFF42, 1'b0};

    rst    = 1'b1;
    dato   = '0;
    inicio = 1'b0;
    prev0  = '0;
    prev1  = '0;
    perr   = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all("idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_conv(tabla[i].dato, 0, 0, tabla[i].exp0, tabla[i].exp1, tabla[i].err,
               $sformatf("tabla%0d v=%0d", i, tabla[i].dato));
    end

    // Second start request mid-conversion must be ignored.
    run_conv(1234, 5, 8888, 16'h1234, 16'h1234, 1'b0, "ignora_inicio");
    @(negedge clk);
    check_all("ignora_inicio idle", 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    dato   = 14'd4321;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    prev0 = '0;
    prev1 = '0;
    perr  = 1'b0;
    check_all("rst async", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check_all($sformatf("post rst k=%0d", k), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    end
    run_conv(56, 0, 0, 16'h0056, 16'hFF56, 1'b0, "tras_rst");

    // Random values, some out of range, with random ignored retriggers.
    for (int i = 0; i < 24; i++) begin
      int v;
      int inj;
      v   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                        : int'($urandom_range(0, 9999));
      inj = int'($urandom_range(0, 15));
      run_conv(v, inj, int'($urandom_range(0, 16383)), modelo(v, 1'b0), modelo(v, 1'b1),
               (v > 9999), $sformatf("rand%0d v=%0d", i, v));
    end

    // Start held high: back-to-back conversions every 16 clocks.
    @(negedge clk);
    dato   = 14'd77;
    inicio = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      logic fin_k;
      @(negedge clk);
      fin_k = (k == 15) || (k == 31);
      chk($sformatf("continuo listo0 k=%0d", k), 32'(li0), 32'(fin_k));
      chk($sformatf("continuo listo1 k=%0d", k), 32'(li1), 32'(fin_k));
      chk($sformatf("continuo ocupado0 k=%0d", k), 32'(oc0), 32'(!fin_k && k != 32));
      chk($sformatf("continuo ocupado1 k=%0d", k), 32'(oc1), 32'(!fin_k && k != 32));
      if (k == 15) begin
        check_all("continuo digitos", 1'b0, 1'b1, 16'h0077, 16'hFF77, 1'b0);
      end
      if (k == 31) inicio = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
